// File: rtl/uart_pkg.sv
// Definitions shared across the serial link: frame state encoding,
// default frame geometry and the data parity helper.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE_S   = 3'd0,
    START_S  = 3'd1,
    DATA_S   = 3'd2,
    PARITY_S = 3'd3,
    STOP_S   = 3'd4
  } uart_state_e;

  // XOR of the low nbits of data; bits above nbits are not part of the payload.
  function automatic logic data_parity(input logic [7:0] data, input int nbits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) begin
        p = p ^ data[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/transmitter.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop
// bits, timed by the shared oversampling strobe, with a one-deep holding register.
module transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 br_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // Wide enough to count two stop bits in one stretch.
  localparam int              TW        = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0]   TICK_ONE  = TW'(1);
  localparam logic [TW-1:0]   BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]   STOP_LAST = TW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic            ODD_BIT   = (PARITY_ODD != 0);
  localparam uart_state_e     POST_DATA = (PARITY_EN != 0) ? PARITY_S : STOP_S;

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept_s;
  logic                 load_s;
  logic                 bit_end_s;

  assign accept_s  = tx_start && !hold_full_q;
  assign bit_end_s = br_tick && (tick_q == BIT_LAST);

  // Next-state logic for the frame sequencer, counters and holding register.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    parity_d    = parity_q;
    done_d      = 1'b0;
    load_s      = 1'b0;

    if (accept_s) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end

    case (state_q)
      IDLE_S: begin
        if (hold_full_q) begin
          load_s  = 1'b1;
          tick_d  = '0;
          state_d = START_S;
        end else begin
          state_d = IDLE_S;
        end
      end
      START_S: begin
        if (bit_end_s) begin
          tick_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA_S;
        end else if (br_tick) begin
          tick_d = tick_q + TICK_ONE;
        end else begin
          tick_d = tick_q;
        end
      end
      DATA_S: begin
        if (bit_end_s) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = POST_DATA;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else if (br_tick) begin
          tick_d = tick_q + TICK_ONE;
        end else begin
          tick_d = tick_q;
        end
      end
      PARITY_S: begin
        if (bit_end_s) begin
          tick_d  = '0;
          state_d = STOP_S;
        end else if (br_tick) begin
          tick_d = tick_q + TICK_ONE;
        end else begin
          tick_d = tick_q;
        end
      end
      STOP_S: begin
        if (br_tick && (tick_q == STOP_LAST)) begin
          done_d = 1'b1;
          tick_d = '0;
          // A byte already waiting is chained with no idle gap; one accepted
          // in this very cycle is not yet visible and starts from IDLE.
          if (hold_full_q) begin
            load_s  = 1'b1;
            state_d = START_S;
          end else begin
            state_d = IDLE_S;
          end
        end else if (br_tick) begin
          tick_d = tick_q + TICK_ONE;
        end else begin
          tick_d = tick_q;
        end
      end
      default: begin
        state_d = IDLE_S;
        tick_d  = '0;
        bit_d   = 3'd0;
      end
    endcase

    if (load_s) begin
      shift_d     = hold_q;
      parity_d    = data_parity(8'(hold_q), DATA_BITS);
      hold_full_d = 1'b0;
    end else begin
      shift_d = shift_d;
    end
  end

  // Line level and status follow the state being entered so they register cleanly.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE_S:   tx_d = 1'b1;
      START_S:  tx_d = 1'b0;
      DATA_S:   tx_d = shift_d[0];
      PARITY_S: tx_d = parity_d ^ ODD_BIT;
      STOP_S:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE_S);
  end

  // State, counters, holding register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE_S;
      tick_q      <= '0;
      bit_q       <= 3'd0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      parity_q    <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      parity_q    <= parity_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = !hold_full_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: an 8N1 instance and an 8E2 instance,
// frame-level bit timing checks and a loopback through a bench-side receiver.
module tb_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       br_tick = 1'b0;
  logic       tx_start_a = 1'b0;
  logic       tx_start_b = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_a, tx_ready_a, tx_busy_a, tx_done_a;
  logic       tx_b, tx_ready_b, tx_busy_b, tx_done_b;

  int checks = 0;
  int errors = 0;
  int tick_div = 2;
  int div_cnt = 0;
  int sel = 0;
  int done_a = 0;
  int done_b = 0;
  logic rx_en = 1'b0;
  logic [7:0] rx_q[$];
  int frame_err = 0;

  transmitter #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .br_tick(br_tick), .tx_start(tx_start_a), .tx_data(tx_data),
    .tx(tx_a), .tx_ready(tx_ready_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a)
  );

  transmitter #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset(reset), .br_tick(br_tick), .tx_start(tx_start_b), .tx_data(tx_data),
    .tx(tx_b), .tx_ready(tx_ready_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
  );

  always #5 clk = ~clk;

  // Baud strobe: updated 1 time unit after each edge, one pulse every tick_div cycles.
  always begin
    @(posedge clk);
    #1;
    div_cnt = (div_cnt + 1) % tick_div;
    br_tick = (div_cnt == 0);
  end

  // Count tx_done pulses away from the active edge.
  always @(negedge clk) begin
    if (tx_done_a) done_a <= done_a + 1;
    if (tx_done_b) done_b <= done_b + 1;
  end

  // Bench receiver on tx_a, valid while br_tick is high every cycle (16 cycles per bit).
  always begin
    @(negedge clk);
    if (rx_en && tx_a === 1'b0) begin
      logic [7:0] rb;
      repeat (7) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        rb[i] = tx_a;
      end
      repeat (16) @(negedge clk);
      if (tx_a !== 1'b1) frame_err = frame_err + 1;
      rx_q.push_back(rb);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic cur_tx();    return (sel == 0) ? tx_a : tx_b;             endfunction
  function automatic logic cur_ready(); return (sel == 0) ? tx_ready_a : tx_ready_b; endfunction
  function automatic logic cur_busy();  return (sel == 0) ? tx_busy_a : tx_busy_b;   endfunction
  function automatic logic cur_done();  return (sel == 0) ? tx_done_a : tx_done_b;   endfunction
  function automatic int   cur_dcnt();  return (sel == 0) ? done_a : done_b;         endfunction

  task automatic drive_start(input logic v);
    if (sel == 0) tx_start_a = v;
    else          tx_start_b = v;
  endtask

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", name, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Step until one br_tick has been consumed, tx required to hold exp_tx throughout.
  task automatic next_tick(input logic exp_tx, input logic fire, input logic [7:0] fdata,
                           output logic bad, output logic obs);
    int n;
    n = 0;
    bad = 1'b0;
    obs = exp_tx;
    while (1) begin
      if (cur_tx() !== exp_tx) begin
        bad = 1'b1;
        obs = cur_tx();
      end
      if (br_tick === 1'b1) begin
        if (fire) begin
          drive_start(1'b1);
          tx_data = fdata;
        end
        step();
        drive_start(1'b0);
        return;
      end
      step();
      n++;
      if (n > 64) begin
        bad = 1'b1;
        return;
      end
    end
  endtask

  // Checks a whole frame from the first cycle of its start bit; optional requests
  // are issued at the first tick of given bits or on the final stop tick.
  task automatic check_frame(input string name, input logic [7:0] data,
                             input int q_bit, input logic [7:0] q_data,
                             input int q2_bit, input logic [7:0] q2_data,
                             input logic lf, input logic [7:0] lf_data);
    logic exp_bits[12];
    int   n;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = data[i];
    if (sel == 0) begin
      exp_bits[9] = 1'b1;
      n = 10;
    end else begin
      exp_bits[9]  = ^data;
      exp_bits[10] = 1'b1;
      exp_bits[11] = 1'b1;
      n = 12;
    end
    for (int b = 0; b < n; b++) begin
      logic bitbad, bad, obs, seen;
      bitbad = 1'b0;
      seen = exp_bits[b];
      for (int k = 0; k < 16; k++) begin
        logic fire;
        logic [7:0] fd;
        fire = 1'b0;
        fd = 8'h00;
        if (b == q_bit && k == 0)  begin fire = 1'b1; fd = q_data;  end
        if (b == q2_bit && k == 0) begin fire = 1'b1; fd = q2_data; end
        if (lf && b == n - 1 && k == 15) begin fire = 1'b1; fd = lf_data; end
        next_tick(exp_bits[b], fire, fd, bad, obs);
        if (bad) begin
          bitbad = 1'b1;
          seen = obs;
        end
      end
      checks++;
      if (bitbad) begin
        errors++;
        $display("FAIL %s bit%0d: tx got %0b want %0b for 16 ticks", name, b, seen, exp_bits[b]);
      end
    end
    chk({name, "_done"}, cur_done(), 1'b1);
  endtask

  task automatic send_accept(input logic [7:0] d);
    drive_start(1'b1);
    tx_data = d;
    step();
    drive_start(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    sel = 0;
    chk("rst_tx", tx_a, 1'b1);
    chk("rst_ready", tx_ready_a, 1'b1);
    chk("rst_busy", tx_busy_a, 1'b0);
    chk("rst_done", tx_done_a, 1'b0);
    chk("rst_tx_b", tx_b, 1'b1);
    reset = 1'b0;
    step();
  endtask

  task automatic test_8n1();
    int d0;
    sel = 0;
    d0 = done_a;
    send_accept(8'h55);
    chk("lat_ready_n1", tx_ready_a, 1'b0);
    chk("lat_busy_n1", tx_busy_a, 1'b0);
    step();
    chk("lat_tx_n2", tx_a, 1'b0);
    chk("lat_busy_n2", tx_busy_a, 1'b1);
    chk("lat_ready_n2", tx_ready_a, 1'b1);
    check_frame("f55", 8'h55, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00);
    chk("f55_idle_tx", tx_a, 1'b1);
    step();
    chk("f55_busy_after", tx_busy_a, 1'b0);
    chk("f55_done_low", tx_done_a, 1'b0);
    chk_int("f55_done_cnt", done_a - d0, 1);
  endtask

  task automatic test_back_to_back();
    int d0;
    sel = 0;
    d0 = done_a;
    send_accept(8'hA3);
    step();
    check_frame("b2b_a3", 8'hA3, 3, 8'h3C, -1, 8'h00, 1'b0, 8'h00);
    chk("b2b_chain_tx", tx_a, 1'b0);
    chk("b2b_chain_busy", tx_busy_a, 1'b1);
    check_frame("b2b_3c", 8'h3C, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00);
    step();
    chk("b2b_busy_after", tx_busy_a, 1'b0);
    chk_int("b2b_done_cnt", done_a - d0, 2);
  endtask

  task automatic test_full();
    int d0;
    sel = 0;
    d0 = done_a;
    send_accept(8'h11);
    drive_start(1'b1);
    tx_data = 8'h33;
    chk("full_ready0", tx_ready_a, 1'b0);
    step();
    drive_start(1'b0);
    chk("full_start_tx", tx_a, 1'b0);
    check_frame("full_11", 8'h11, 2, 8'h22, 5, 8'h33, 1'b0, 8'h00);
    check_frame("full_22", 8'h22, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00);
    repeat (40) step();
    chk("full_idle_busy", tx_busy_a, 1'b0);
    chk("full_idle_tx", tx_a, 1'b1);
    chk_int("full_done_cnt", done_a - d0, 2);
  endtask

  task automatic test_parity_two_stop();
    int d0;
    sel = 1;
    d0 = done_b;
    send_accept(8'h07);
    chk("par_ready_n1", tx_ready_b, 1'b0);
    step();
    check_frame("par_07", 8'h07, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00);
    step();
    chk("par_busy_after", tx_busy_b, 1'b0);
    chk_int("par_done_cnt", done_b - d0, 1);
    sel = 0;
  endtask

  task automatic test_last_tick_accept();
    sel = 0;
    send_accept(8'h81);
    step();
    check_frame("lt_81", 8'h81, -1, 8'h00, -1, 8'h00, 1'b1, 8'h6E);
    chk("lt_not_chained_tx", tx_a, 1'b1);
    chk("lt_not_chained_busy", tx_busy_a, 1'b0);
    chk("lt_held", tx_ready_a, 1'b0);
    step();
    chk("lt_start_tx", tx_a, 1'b0);
    chk("lt_start_busy", tx_busy_a, 1'b1);
    check_frame("lt_6e", 8'h6E, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00);
    step();
  endtask

  task automatic test_midframe_reset();
    logic [9:0] seq;
    logic       anybad, bad, obs;
    int         d0;
    sel = 0;
    seq = {1'b1, 8'h5A, 1'b0};
    anybad = 1'b0;
    send_accept(8'h5A);
    step();
    for (int t = 0; t < 64; t++) begin
      next_tick(seq[t / 16], (t == 20), 8'h99, bad, obs);
      anybad = anybad | bad;
    end
    chk("mr_partial_ok", anybad, 1'b0);
    d0 = done_a;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_tx", tx_a, 1'b1);
    chk("mr_ready", tx_ready_a, 1'b1);
    chk("mr_busy", tx_busy_a, 1'b0);
    chk("mr_done", tx_done_a, 1'b0);
    repeat (60) step();
    chk("mr_held_dropped", tx_busy_a, 1'b0);
    chk_int("mr_no_done", done_a - d0, 0);
    send_accept(8'hC3);
    step();
    check_frame("mr_c3", 8'hC3, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00);
    step();
    chk_int("mr_c3_done_cnt", done_a - d0, 1);
  endtask

  task automatic test_loopback();
    int d0;
    int w;
    logic timeout;
    sel = 0;
    tick_div = 1;
    repeat (4) step();
    rx_q.delete();
    frame_err = 0;
    rx_en = 1'b1;
    d0 = done_a;
    timeout = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = 0;
      while (tx_ready_a !== 1'b1 && w < 400) begin
        step();
        w++;
      end
      if (w >= 400) begin
        timeout = 1'b1;
        break;
      end
      send_accept(8'(i));
    end
    chk("lb_ready_timeout", timeout, 1'b0);
    w = 0;
    while ((done_a - d0) < 256 && w < 2000) begin
      step();
      w++;
    end
    repeat (4) step();
    rx_en = 1'b0;
    chk_int("lb_done_cnt", done_a - d0, 256);
    chk_int("lb_rx_cnt", rx_q.size(), 256);
    chk_int("lb_frame_err", frame_err, 0);
    for (int i = 0; i < 256 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i)) begin
        errors++;
        $display("FAIL lb_byte%0d: got %02h want %02h", i, rx_q[i], 8'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_back_to_back();
    test_full();
    test_parity_two_stop();
    test_last_tick_accept();
    test_midframe_reset();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/transmitter.md
# transmitter

UART transmit half of the serial link: serialises parallel bytes onto the `tx` line as start bit, data bits LSB first, optional parity bit and stop bit(s). All bit timing is derived from the shared 16× oversampling `br_tick` strobe, the same one that feeds the link's receiver. A one-deep holding register lets the next byte be queued while the current frame is on the wire, so consecutive frames go out with no idle gap between them.

## Interface
- `DATA_BITS`, 8: payload bits per frame, legal range 5–8.
- `OVERSAMPLE`, 16: `br_tick` pulses per bit period.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `clk` input 1: system clock; the only clock.
- `reset` input 1: synchronous, active-high reset.
- `br_tick` input 1: one-`clk`-wide baud strobe at OVERSAMPLE× bit rate.
- `tx_start` input 1: request to send `tx_data`; accepted only when `tx_ready`=1.
- `tx_data` input DATA_BITS: byte to send, captured on acceptance.
- `tx` output 1: serial line, registered, idles high.
- `tx_ready` output 1: holding register empty, so a request can be accepted.
- `tx_busy` output 1: a frame is in progress (state ≠ IDLE).
- `tx_done` output 1: one-cycle pulse at the end of each frame's last stop bit.

## Operation
- **Accept:** `tx_start`&&`tx_ready` copies `tx_data` into the holding register and sets hold_full. `tx_start` while `tx_ready`=0 is ignored with no side effect. `tx_data` is don't-care outside the accept cycle.
- **States:** IDLE, START, DATA, PARITY, STOP. A tick counter `tick_cnt` and a bit counter `bit_cnt` run alongside the state.
- **IDLE:** `tx`=1 and `br_tick` is ignored. If hold_full, then on the next edge the holding register moves to the shift register, hold_full clears, `tick_cnt`=0 and the state goes to START.
- **START:** `tx`=0. Each `br_tick` increments `tick_cnt`. At `tick_cnt`==OVERSAMPLE-1 with `br_tick`, set `tick_cnt`=0, `bit_cnt`=0 and go to DATA.
- **DATA:** `tx`=shift[0]. At the end of each bit period, shift right. After bit DATA_BITS-1, go to PARITY if `PARITY_EN`, otherwise to STOP.
- **PARITY:** `tx` = XOR of the data bits, XOR'd with `PARITY_ODD`. Lasts one bit period, then go to STOP.
- **STOP:** `tx`=1 for STOP_BITS×OVERSAMPLE ticks. On the final tick, pulse `tx_done`. If hold_full, reload the shift register and go straight to START (back-to-back, no idle gap); otherwise go to IDLE.
- **Counter widths:** `tick_cnt` is clog2(2×OVERSAMPLE) bits so it covers two stop bits. `bit_cnt` is 3 bits.

## Timing
- **Reset values:** `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0; hold_full=0; state IDLE; all counters 0.
- **Start latency:** with `tx_start` accepted in cycle N while IDLE:
  - hold_full=1 and `tx_ready`=0 at N+1;
  - state=START, `tx`=0, `tx_busy`=1 at N+2;
  - `tx_ready`=1 again at N+2.
- **Bit length:** the start bit is counted from state entry, so it lasts OVERSAMPLE `br_tick` periods plus less than one tick period of phase error. Every later bit is exactly OVERSAMPLE `br_tick` periods.
- **Stop and `tx_done`:** `tx_done` is high for the single cycle after the final stop tick. In that same cycle `tx` is 1 (returning to IDLE) or 0 (back-to-back START).
- **Accept during the last stop tick:** a request accepted in the same cycle as the final stop tick is not chained into that transition. It is captured and starts from IDLE two cycles later.
- **Mid-frame reset:** `reset` asserted mid-frame forces every reset value at the next edge. The partial frame and the held byte are discarded.
- **`br_tick` in consecutive cycles:** each one counts; no filtering.

## Structure
- **Shared package `uart_pkg`:**
  - state encoding localparams (IDLE_S, START_S, DATA_S, PARITY_S, STOP_S);
  - default OVERSAMPLE and DATA_BITS, also used by the receiver and baud generator.
- **Sub-modules:** none required. The state machine, holding register and counters are one module, using the two-process pattern (state register + next-state logic) in the style of the receiver.

## Test plan
- **8N1, 0x55:** accepted while idle -> `tx` sequence 0,1,0,1,0,1,0,1,0,1, each 16 `br_tick` periods. One `tx_done` pulse, then `tx_busy`=0.
- **Back-to-back:** 0xA3, with 0x3C accepted during 0xA3's DATA state -> the stop bit of 0xA3 is followed directly by the start bit of 0x3C. `tx` is never high for more than 16 ticks between frames, and there are two `tx_done` pulses.
- **Request while full:** 0x11 sent, 0x22 queued, then `tx_start` with 0x33 while `tx_ready`=0 -> only 0x11 and 0x22 are transmitted.
- **Even parity, 0x07:** `PARITY_EN`=1, `PARITY_ODD`=0 -> parity bit=1. With `STOP_BITS`=2, the stop time is 32 ticks before `tx_done`.
- **Mid-frame reset:** `reset` for 1 cycle in the middle of DATA -> `tx`=1, `tx_ready`=1, `tx_busy`=0 next cycle. No `tx_done`, and the next request transmits cleanly.
- **Loopback:** `tx` looped to the receiver for all 256 byte values -> `rx_data` equals the sent byte on every `rx_done`.
